// File: rtl/ysyx_22041412_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the
// decode-side queue head. master = fetch unit, slave = memory/decode environment.
interface ysyx_22041412_ifu_if;
  // Handshake rule: a transfer happens on a rising edge where valid & ready are
  // both high; a producer holds valid until it fires unless a redirect cancels it.
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );
endinterface

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: PC owner, one-outstanding imem fetcher, {pc,instr} queue.
// Optional early jal redirect from decode: define YSYX_22041412_IFU_JAL_EARLY_EN.
module ysyx_22041412_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22041412_ifu_if.master        bus,
  input  logic                       ex_redirect,
  input  logic [63:0]                ex_redirect_pc,
  input  logic                       jal_ok,
  input  logic [63:0]                jal_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        drop_q, drop_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pc_mem_q [QDEPTH];
  logic [31:0] pc_mem_d [QDEPTH];
  logic [31:0] instr_mem_q [QDEPTH];
  logic [31:0] instr_mem_d [QDEPTH];

  logic        jal_ok_eff, redir, room, req_valid, fire, id_valid, push, pop;
  logic [31:0] target;
  logic        unused_bits;

  // Every redirect input bit is consumed so the upper halves do not dangle.
  assign unused_bits = ^{ex_redirect_pc, jal_pc, jal_ok};

  always_comb begin
`ifdef YSYX_22041412_IFU_JAL_EARLY_EN
    jal_ok_eff = jal_ok & ~ex_redirect;
`else
    jal_ok_eff = 1'b0;
`endif
    redir  = ex_redirect | jal_ok_eff;
    target = ex_redirect ? {ex_redirect_pc[31:2], 2'b00} : {jal_pc[31:2], 2'b00};
    // Reserve a slot for the in-flight word so a push never meets a full queue.
    room      = (count_q + CW'(outstanding_q)) < CW'(QDEPTH);
    req_valid = ~rst & ~redir & (~outstanding_q | (bus.imem_resp_valid & ~drop_q)) & room;
    fire      = req_valid & bus.imem_req_ready;
    id_valid  = (count_q != '0);
    push      = bus.imem_resp_valid & ~drop_q & ~redir;
    pop       = id_valid & bus.id_ready & ~redir;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;

    if (fire) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
      outstanding_d = 1'b1;
    end else if (bus.imem_resp_valid) begin
      outstanding_d = 1'b0;
    end
    if (bus.imem_resp_valid) drop_d = 1'b0;

    if (redir) begin
      fetch_pc_d = target;
      // The word still in flight belongs to the old path; discard it on arrival.
      if (outstanding_q && !bus.imem_resp_valid) drop_d = 1'b1;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = inflight_pc_q;
        instr_mem_d[tail_q] = bus.imem_resp_data;
        tail_d              = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_pc          = id_valid ? pc_mem_q[head_q] : 32'h0000_0000;
  assign bus.id_instr       = id_valid ? instr_mem_q[head_q] : 32'h0000_0013;
endmodule

// File: doc/ysyx_22041412_ifu.md
# ysyx_22041412_ifu

Instruction fetch unit: owns the architectural fetch PC, issues 32-bit instruction fetches to instruction memory over a valid/ready request channel, and buffers returned words in a small queue. It presents `{pc, instr}` pairs to the decode stage with a valid/ready handshake. It accepts PC redirects from execute (branch/jalr/fence.i refetch) and the early `jal_ok`/`jal_pc` redirect that decode produces.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, first fetch address after reset
- `QDEPTH`, 4, instruction queue entries; power of two, minimum 2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  32  fetch address, word aligned
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response word valid; exactly one per accepted request, never in the accept cycle
- `imem_resp_data`  in  32  instruction word
- `id_valid`  out  1  decode-side entry valid
- `id_ready`  in  1  decode consumes entry
- `id_instr`  out  32  instruction to decode
- `id_pc`  out  32  PC of `id_instr`
- `ex_redirect`  in  1  execute-stage redirect
- `ex_redirect_pc`  in  64  redirect target; bits [31:2] used
- `jal_ok`  in  1  early jal redirect from decode
- `jal_pc`  in  64  jal target; bits [31:2] used

## Operation
- State: `fetch_pc` (32), `outstanding` (1), `drop` (1), `inflight_pc` (32), and a circular queue of `QDEPTH` `{pc, instr}` entries with head, tail and count.
- `redir` = `ex_redirect | jal_ok_eff`, where `jal_ok_eff` depends on the configuration below. Target = `ex_redirect_pc` if `ex_redirect`, else `jal_pc`; `ex_redirect` has priority. Bits [1:0] of the target are forced to 0.
- Request: `imem_req_valid = !rst & !redir & (!outstanding | (imem_resp_valid & !drop)) & (count + outstanding < QDEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On fire (valid & ready): `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps mod 2^32), `outstanding <= 1`.
- Response:
  - If `drop` is set, or `redir` is high in the same cycle, the word is discarded.
  - Otherwise `{inflight_pc, imem_resp_data}` is pushed at the tail.
  - Either way, `outstanding` clears unless a new request fires in the same cycle, and `drop` clears.
- Dequeue: `id_valid = (count != 0)`. Head entry drives `id_pc`/`id_instr`. It pops on `id_valid & id_ready`.
  - When the queue is empty, `id_instr = 32'h0000_0013` and `id_pc = 0`.
- Redirect cycle:
  - Queue flushed (count 0, head = tail); the pop and push in that cycle are ignored.
  - `fetch_pc <= target`.
  - If `outstanding` is set and no response arrives this cycle, `drop <= 1`.
  - No request issues this cycle.
- Simultaneous push and pop: count unchanged. Push is never attempted when the queue is full; the reservation rule guarantees this. Full queue plus outstanding request: no new request.

## Timing
- Reset values: `fetch_pc = RESET_PC`, `outstanding = 0`, `drop = 0`, count 0, `id_valid = 0`, `imem_req_valid = 0` while `rst` is high.
- Reset asserted mid-operation: all state returns to reset values at the next edge. A response arriving after reset deasserts without a matching request is illegal and need not be handled.
- Latency: `rst` falls before edge E0 → `imem_req_valid` high in cycle 0. With 1-cycle memory, response in cycle 1 and `id_valid` in cycle 2 (no bypass from response to decode).
- Throughput: with 1-cycle memory and `id_ready` held high, one instruction per cycle in steady state. A new request issues in the cycle its predecessor's response arrives.
- Redirect to first new instruction: `redir` at cycle R, request at R+1, `id_valid` at R+3 (1-cycle memory).
- `imem_req_addr` changes while `imem_req_valid & !imem_req_ready` only across a redirect. In that case `req_valid` drops in the redirect cycle.
- Combinational paths: `redir` inputs and `imem_resp_valid` to `imem_req_valid`. No path from `id_ready`.

## Configuration
- `YSYX_22041412_IFU_JAL_EARLY_EN` defined: `jal_ok_eff = jal_ok & !ex_redirect`; decode's early jal target redirects fetch.
- Not defined: `jal_ok_eff = 0`. `jal_ok`/`jal_pc` are ignored and jal is resolved through `ex_redirect` only.

## Test plan
- Reset release, memory always ready, 1-cycle responses, `id_ready = 1` → requests to 8000_0000, 8000_0004, …; `id_valid` from cycle 2 with `id_pc` incrementing by 4 every cycle.
- `id_ready = 0` for 10 cycles → exactly 4 entries queued, `imem_req_valid` low. Release → entries drain in order 8000_0000..8000_000C with no loss or duplication.
- Request accepted at 8000_0008, `ex_redirect` with 8000_0100 the next cycle before the response → stale word dropped; next `id_pc` is 8000_0100.
- `ex_redirect` (target 8000_0200) and `jal_ok` (target 8000_0300) in the same cycle, macro defined → fetch resumes at 8000_0200.
- `jal_ok` with `jal_pc = 64'h0000_0000_8000_0042` → fetch from 8000_0040 when the macro is defined; no effect when undefined.
- `fetch_pc = 32'hFFFF_FFFC` → next request address is 32'h0000_0000.
